immediate_sequencer: RTL

Two-stage pipelined controller for the immediate and displacement datapath. It takes a fetched instruction word and its PC, decodes the SPARC V8 format, and selects the matching sign extension: simm13, disp22, disp30, or a SETHI imm22 placement. For PC-relative formats it also computes the target address. Results go to the execute/branch logic over a valid/ready handshake, and the block supports back-pressure and pipeline flush.

---
 rtl/immediate_sequencer_if.sv | 41 ++++
 rtl/immediate_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/immediate_sequencer_if.sv
// Handshake bundle between the fetch side, the immediate sequencer and the
// execute/branch consumer. The master side drives instructions, flush and
// out_ready; the slave side (the sequencer) returns the decoded result.
interface immediate_sequencer_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [2:0]  out_kind;
    logic [15:0] done_count;

    modport master (
        output flush,
        output in_valid,
        output in_instr,
        output in_pc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  out_kind,
        input  done_count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_instr,
        input  in_pc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_value,
        output out_kind,
        output done_count
    );
endinterface

// File: rtl/immediate_sequencer.sv
// Two-stage immediate/displacement sequencer for SPARC V8 instruction words.
// S1 holds the decoded kind, the pre-shifted extended field and the PC;
// S2 holds the final value (PC-relative targets already added) and drives
// the consumer over a valid/ready handshake with back-pressure and flush.
module immediate_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    immediate_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        KIND_NONE   = 3'd0,
        KIND_CALL   = 3'd1,
        KIND_BRANCH = 3'd2,
        KIND_SETHI  = 3'd3,
        KIND_SIMM13 = 3'd4,
        KIND_REG    = 3'd5
    } kind_e;

    // Instruction fields used by the decoder
    logic [1:0]  op;
    logic [2:0]  op2;
    logic        iBit;

    // Decoder results for the word currently on the input
    kind_e       decKind;
    logic [31:0] decExt;

    // Stage 1 state
    logic        s1Valid_q;
    logic        s1Valid_d;
    kind_e       s1Kind_q;
    logic [31:0] s1Ext_q;
    logic [31:0] s1Pc_q;

    // Stage 2 state
    logic        s2Valid_q;
    logic        s2Valid_d;
    kind_e       s2Kind_q;
    logic [31:0] s2Value_q;
    logic [31:0] s2Value_d;

    // Completed-transfer counter
    logic [15:0] doneCount_q;
    logic [15:0] doneCount_d;

    // Handshake qualifiers
    logic        outValid;
    logic        inReady;
    logic        accept;
    logic        transfer;
    logic        s2Advance;

    assign op   = bus.in_instr[31:30];
    assign op2  = bus.in_instr[24:22];
    assign iBit = bus.in_instr[13];

    // Classify the instruction and build its sign-extended, pre-shifted field
    always_comb begin
        decKind = KIND_NONE;
        decExt  = '0;
        case (op)
            2'b01: begin
                decKind = KIND_CALL;
                decExt  = {bus.in_instr[29:0], 2'b00};
            end
            2'b00: begin
                case (op2)
                    3'b010, 3'b110, 3'b111: begin
                        decKind = KIND_BRANCH;
                        decExt  = {{8{bus.in_instr[21]}}, bus.in_instr[21:0], 2'b00};
                    end
                    3'b100: begin
                        decKind = KIND_SETHI;
                        decExt  = {bus.in_instr[21:0], 10'b0};
                    end
                    default: begin
                        decKind = KIND_NONE;
                        decExt  = '0;
                    end
                endcase
            end
            default: begin
                if (iBit) begin
                    decKind = KIND_SIMM13;
                    decExt  = {{19{bus.in_instr[12]}}, bus.in_instr[12:0]};
                end else begin
                    decKind = KIND_REG;
                    decExt  = '0;
                end
            end
        endcase
    end

    // Handshake: flush blocks both ends; S2 moves when empty or draining
    always_comb begin
        outValid  = s2Valid_q && !bus.flush;
        transfer  = outValid && bus.out_ready;
        inReady   = !bus.flush && (!s1Valid_q || !s2Valid_q || bus.out_ready);
        accept    = bus.in_valid && inReady;
        s2Advance = !bus.flush && (!s2Valid_q || transfer);
    end

    // Next-state for valid flags, the S2 value and the transfer counter
    always_comb begin
        s1Valid_d = s1Valid_q;
        if (bus.flush) begin
            s1Valid_d = 1'b0;
        end else if (accept) begin
            s1Valid_d = 1'b1;
        end else if (s2Advance) begin
            s1Valid_d = 1'b0;
        end

        s2Valid_d = s2Valid_q;
        if (bus.flush) begin
            s2Valid_d = 1'b0;
        end else if (s2Advance) begin
            s2Valid_d = s1Valid_q;
        end

        if ((s1Kind_q == KIND_CALL) || (s1Kind_q == KIND_BRANCH)) begin
            s2Value_d = s1Pc_q + s1Ext_q;
        end else begin
            s2Value_d = s1Ext_q;
        end

        doneCount_d = doneCount_q;
        if (transfer) begin
            doneCount_d = doneCount_q + 16'd1;
        end
    end

    // Stage 1 register: capture a decoded input on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1Kind_q  <= KIND_NONE;
            s1Ext_q   <= '0;
            s1Pc_q    <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            if (accept) begin
                s1Kind_q <= decKind;
                s1Ext_q  <= decExt;
                s1Pc_q   <= bus.in_pc;
            end
        end
    end

    // Stage 2 register: load only real entries so a stalled output stays put
    always_ff @(posedge clk) begin
        if (reset) begin
            s2Valid_q <= 1'b0;
            s2Kind_q  <= KIND_NONE;
            s2Value_q <= '0;
        end else begin
            s2Valid_q <= s2Valid_d;
            if (s2Advance && s1Valid_q) begin
                s2Kind_q  <= s1Kind_q;
                s2Value_q <= s2Value_d;
            end
        end
    end

    // Transfer counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            doneCount_q <= '0;
        end else begin
            doneCount_q <= doneCount_d;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid;
    assign bus.out_value  = s2Value_q;
    assign bus.out_kind   = s2Kind_q;
    assign bus.done_count = doneCount_q;

endmodule
